// File: rtl/bp_resolve_queue_pkg.sv
// Shared types for the branch resolve queue: queue entry layout, FSM states and
// the mispredict rule applied to the oldest in-flight prediction.
package bp_resolve_queue_pkg;

    localparam int BP_XLEN = 32;
    localparam logic [BP_XLEN-1:0] BP_PC_INC = BP_XLEN'(4);

    typedef enum logic {
        BP_RUN   = 1'b0,
        BP_FLUSH = 1'b1
    } bp_state_e;

    typedef struct packed {
        logic [BP_XLEN-1:0] pc;
        logic               hit;
        logic               taken;
        logic [BP_XLEN-1:0] target;
    } bp_entry_t;

    // A non-branch can only be wrong when a stale BTB alias predicted it taken.
    function automatic logic bp_is_mispredict(
        input bp_entry_t          e,
        input logic               is_branch,
        input logic               act_taken,
        input logic [BP_XLEN-1:0] act_target
    );
        logic pred_tk;
        pred_tk = e.hit && e.taken;
        if (!is_branch) begin
            return pred_tk;
        end
        return (pred_tk && !act_taken) ||
               (!pred_tk && act_taken) ||
               (pred_tk && act_taken && (e.target != act_target));
    endfunction

endpackage

// File: rtl/bp_resolve_queue_if.sv
// Fetch/execute/BTB-facing signal bundle of the resolve queue.
// slave is the queue itself, master is the surrounding pipeline.
interface bp_resolve_queue_if #(
    parameter int XLEN = 32
);
    logic            pred_push;
    logic [XLEN-1:0] pred_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            pred_full;

    logic            res_valid;
    logic            res_is_branch;
    logic            res_taken;
    logic [XLEN-1:0] res_target;

    logic            update;
    logic [XLEN-1:0] update_pc;
    logic [XLEN-1:0] update_target;
    logic            mispredicted;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic [31:0]     branch_count;
    logic [31:0]     mispredict_count;
    logic            order_error;

    modport master (
        output pred_push, pred_pc, pred_hit, pred_taken, pred_target,
        output res_valid, res_is_branch, res_taken, res_target,
        input  pred_full, update, update_pc, update_target, mispredicted,
        input  redirect_valid, redirect_pc, flush,
        input  branch_count, mispredict_count, order_error
    );

    modport slave (
        input  pred_push, pred_pc, pred_hit, pred_taken, pred_target,
        input  res_valid, res_is_branch, res_taken, res_target,
        output pred_full, update, update_pc, update_target, mispredicted,
        output redirect_valid, redirect_pc, flush,
        output branch_count, mispredict_count, order_error
    );

endinterface

// File: rtl/bp_resolve_queue_pred_fifo.sv
// Circular buffer of in-flight predictions; clear drops every entry by snapping
// the read pointer onto the write pointer.
module bp_resolve_queue_pred_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_i && !pop_i)      count_d = count_q + CW'(1);
            else if (!push_i && pop_i) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/bp_resolve_queue.sv
// Execute-side resolve queue: checks the oldest fetch prediction against the
// actual outcome and drives BTB updates, front-end redirect/flush and statistics.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   BP_RUN   | normal: accept predictions, resolve the head on res_valid
//   BP_FLUSH | redirect visible; wrong-path entries dropped, inputs ignored
module bp_resolve_queue
    import bp_resolve_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = BP_XLEN
) (
    input logic            clk,
    input logic            rst,
    bp_resolve_queue_if.slave bp
);
    bp_state_e       state_q;
    bp_entry_t       wr_entry;
    bp_entry_t       head;
    logic            fifo_full, fifo_empty;
    logic            run, pop, mis_now, push_ok, clear;

    logic            update_q;
    logic [XLEN-1:0] update_pc_q;
    logic [XLEN-1:0] update_target_q;
    logic            mispredicted_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            flush_q;
    logic [31:0]     branch_count_q;
    logic [31:0]     mispredict_count_q;
    logic            order_error_q;

    assign run   = (state_q == BP_RUN);
    assign clear = (state_q == BP_FLUSH);
    assign pop   = run && bp.res_valid && !fifo_empty;
    assign mis_now = pop && bp_is_mispredict(head, bp.res_is_branch, bp.res_taken, bp.res_target);
    // A push arriving with a mispredict is wrong-path; a full queue only accepts
    // when the head leaves in the same cycle.
    assign push_ok = run && !mis_now && bp.pred_push && (!fifo_full || pop);

    assign wr_entry.pc     = bp.pred_pc;
    assign wr_entry.hit    = bp.pred_hit;
    assign wr_entry.taken  = bp.pred_taken;
    assign wr_entry.target = bp.pred_target;

    bp_resolve_queue_pred_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(bp_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_ok),
        .pop_i   (pop),
        .clear_i (clear),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= BP_RUN;
            update_q           <= 1'b0;
            update_pc_q        <= '0;
            update_target_q    <= '0;
            mispredicted_q     <= 1'b0;
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= '0;
            flush_q            <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            order_error_q      <= 1'b0;
        end else begin
            update_q         <= 1'b0;
            update_pc_q      <= '0;
            update_target_q  <= '0;
            mispredicted_q   <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            case (state_q)
                BP_RUN: begin
                    if (pop) begin
                        if (bp.res_is_branch) begin
                            branch_count_q <= branch_count_q + 32'd1;
                        end
                        // A non-branch mispredict writes the entry to clear the alias.
                        if (bp.res_is_branch || mis_now) begin
                            update_q        <= 1'b1;
                            update_pc_q     <= head.pc;
                            update_target_q <= bp.res_target;
                        end
                        if (mis_now) begin
                            mispredicted_q     <= 1'b1;
                            redirect_valid_q   <= 1'b1;
                            flush_q            <= 1'b1;
                            redirect_pc_q      <= bp.res_taken ? bp.res_target
                                                               : head.pc + BP_PC_INC;
                            mispredict_count_q <= mispredict_count_q + 32'd1;
                            state_q            <= BP_FLUSH;
                        end
                    end else if (bp.res_valid && fifo_empty) begin
                        order_error_q <= 1'b1;
                    end
                end
                BP_FLUSH: state_q <= BP_RUN;
                default:  state_q <= BP_RUN;
            endcase
        end
    end

    assign bp.pred_full        = fifo_full;
    assign bp.update           = update_q;
    assign bp.update_pc        = update_pc_q;
    assign bp.update_target    = update_target_q;
    assign bp.mispredicted     = mispredicted_q;
    assign bp.redirect_valid   = redirect_valid_q;
    assign bp.redirect_pc      = redirect_pc_q;
    assign bp.flush            = flush_q;
    assign bp.branch_count     = branch_count_q;
    assign bp.mispredict_count = mispredict_count_q;
    assign bp.order_error      = order_error_q;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench for bp_resolve_queue: resolve outcomes, flush timing, full/wrap,
// non-branch alias and asynchronous reset, with hand-computed expectations.
module tb_bp_resolve_queue;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    bp_resolve_queue_if #(.XLEN(32)) bus ();

    bp_resolve_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] tgt);
        bus.pred_push   = 1'b1;
        bus.pred_pc     = pc;
        bus.pred_hit    = hit;
        bus.pred_taken  = tk;
        bus.pred_target = tgt;
    endtask

    task automatic set_res(input logic br, input logic tk, input logic [31:0] tgt);
        bus.res_valid     = 1'b1;
        bus.res_is_branch = br;
        bus.res_taken     = tk;
        bus.res_target    = tgt;
    endtask

    task automatic idle_inputs();
        bus.pred_push = 1'b0;
        bus.res_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] tgt);
        set_push(pc, hit, tk, tgt);
        step();
        idle_inputs();
    endtask

    task automatic resolve(input logic br, input logic tk, input logic [31:0] tgt);
        set_res(br, tk, tgt);
        step();
        idle_inputs();
    endtask

    initial begin
        logic [31:0] exp_pc;
        rst = 1'b1;
        bus.pred_push = 1'b0; bus.pred_pc = '0; bus.pred_hit = 1'b0;
        bus.pred_taken = 1'b0; bus.pred_target = '0;
        bus.res_valid = 1'b0; bus.res_is_branch = 1'b0; bus.res_taken = 1'b0;
        bus.res_target = '0;
        step();
        step();
        chk("rst_update", 32'(bus.update), 0);
        chk("rst_mispredicted", 32'(bus.mispredicted), 0);
        chk("rst_redirect_valid", 32'(bus.redirect_valid), 0);
        chk("rst_flush", 32'(bus.flush), 0);
        chk("rst_pred_full", 32'(bus.pred_full), 0);
        chk("rst_branch_count", bus.branch_count, 0);
        chk("rst_order_error", 32'(bus.order_error), 0);
        rst = 1'b0;

        // correctly predicted taken branch
        push(32'h100, 1'b1, 1'b1, 32'h200);
        resolve(1'b1, 1'b1, 32'h200);
        chk("t1_update", 32'(bus.update), 1);
        chk("t1_update_pc", bus.update_pc, 32'h100);
        chk("t1_update_target", bus.update_target, 32'h200);
        chk("t1_mispredicted", 32'(bus.mispredicted), 0);
        chk("t1_flush", 32'(bus.flush), 0);
        chk("t1_branch_count", bus.branch_count, 1);
        step();
        chk("t1_update_pulse", 32'(bus.update), 0);

        // predicted taken, actually not taken, younger entries behind it
        push(32'h100, 1'b1, 1'b1, 32'h200);
        push(32'h200, 1'b0, 1'b0, 32'h0);
        push(32'h204, 1'b0, 1'b0, 32'h0);
        resolve(1'b1, 1'b0, 32'h200);
        chk("t2_mispredicted", 32'(bus.mispredicted), 1);
        chk("t2_redirect_valid", 32'(bus.redirect_valid), 1);
        chk("t2_redirect_pc", bus.redirect_pc, 32'h104);
        chk("t2_flush", 32'(bus.flush), 1);
        chk("t2_update_pc", bus.update_pc, 32'h100);
        chk("t2_mispredict_count", bus.mispredict_count, 1);
        chk("t2_branch_count", bus.branch_count, 2);
        step();
        chk("t2_flush_pulse", 32'(bus.flush), 0);
        chk("t2_redirect_pulse", 32'(bus.redirect_valid), 0);
        resolve(1'b1, 1'b1, 32'h0);
        chk("t2_order_error", 32'(bus.order_error), 1);
        chk("t2_empty_no_update", 32'(bus.update), 0);
        chk("t2_empty_branch_count", bus.branch_count, 2);

        // taken as predicted but to a different target
        push(32'h180, 1'b1, 1'b1, 32'h300);
        resolve(1'b1, 1'b1, 32'h340);
        chk("t3_mispredicted", 32'(bus.mispredicted), 1);
        chk("t3_redirect_pc", bus.redirect_pc, 32'h340);
        chk("t3_update_target", bus.update_target, 32'h340);
        chk("t3_update_pc", bus.update_pc, 32'h180);
        chk("t3_mispredict_count", bus.mispredict_count, 2);
        step();

        // fill, drop when full, push+pop while full, drain across pointer wrap
        push(32'h1000, 1'b0, 1'b0, 32'h0);
        push(32'h1004, 1'b0, 1'b0, 32'h0);
        push(32'h1008, 1'b0, 1'b0, 32'h0);
        chk("t4_not_full_at_3", 32'(bus.pred_full), 0);
        push(32'h100C, 1'b0, 1'b0, 32'h0);
        chk("t4_full_at_4", 32'(bus.pred_full), 1);
        push(32'h1010, 1'b0, 1'b0, 32'h0);
        chk("t4_full_after_drop", 32'(bus.pred_full), 1);
        for (int k = 0; k < 10; k++) begin
            exp_pc = (k < 4) ? 32'h1000 + 32'(4 * k) : 32'h1014 + 32'(4 * (k - 4));
            if (k < 6) set_push(32'h1014 + 32'(4 * k), 1'b0, 1'b0, 32'h0);
            set_res(1'b1, 1'b0, 32'h0);
            step();
            idle_inputs();
            chk($sformatf("t4_pop%0d_pc", k), bus.update_pc, exp_pc);
            chk($sformatf("t4_pop%0d_mis", k), 32'(bus.mispredicted), 0);
            if (k < 6) chk($sformatf("t4_pop%0d_full", k), 32'(bus.pred_full), 1);
        end
        chk("t4_drained_full", 32'(bus.pred_full), 0);
        chk("t4_branch_count", bus.branch_count, 13);

        // stale alias on a non-branch; wrong-path pushes must be dropped
        push(32'h400, 1'b1, 1'b1, 32'h500);
        set_res(1'b0, 1'b0, 32'h0);
        set_push(32'h600, 1'b1, 1'b0, 32'h0);
        step();
        idle_inputs();
        chk("t5_mispredicted", 32'(bus.mispredicted), 1);
        chk("t5_update", 32'(bus.update), 1);
        chk("t5_update_pc", bus.update_pc, 32'h400);
        chk("t5_redirect_pc", bus.redirect_pc, 32'h404);
        chk("t5_branch_count", bus.branch_count, 13);
        chk("t5_mispredict_count", bus.mispredict_count, 3);
        push(32'h700, 1'b0, 1'b0, 32'h0);
        resolve(1'b1, 1'b0, 32'h0);
        chk("t5_wrongpath_dropped", 32'(bus.update), 0);
        chk("t5_branch_count_after", bus.branch_count, 13);

        // predicted not taken, actually taken
        push(32'h800, 1'b0, 1'b0, 32'h0);
        resolve(1'b1, 1'b1, 32'h900);
        chk("t6_mispredicted", 32'(bus.mispredicted), 1);
        chk("t6_redirect_pc", bus.redirect_pc, 32'h900);
        chk("t6_mispredict_count", bus.mispredict_count, 4);
        chk("t6_branch_count", bus.branch_count, 14);
        step();

        // asynchronous reset with entries queued and a mispredict visible
        push(32'hA00, 1'b1, 1'b1, 32'hB00);
        push(32'hA04, 1'b0, 1'b0, 32'h0);
        push(32'hA08, 1'b0, 1'b0, 32'h0);
        resolve(1'b1, 1'b0, 32'h0);
        chk("t7_pre_mispredicted", 32'(bus.mispredicted), 1);
        #1 rst = 1'b1;
        #1;
        chk("t7_rst_mispredicted", 32'(bus.mispredicted), 0);
        chk("t7_rst_flush", 32'(bus.flush), 0);
        chk("t7_rst_redirect_pc", bus.redirect_pc, 0);
        chk("t7_rst_update", 32'(bus.update), 0);
        chk("t7_rst_branch_count", bus.branch_count, 0);
        chk("t7_rst_mispredict_count", bus.mispredict_count, 0);
        chk("t7_rst_order_error", 32'(bus.order_error), 0);
        #3 rst = 1'b0;
        chk("t7_pred_full", 32'(bus.pred_full), 0);
        resolve(1'b1, 1'b1, 32'h0);
        chk("t7_order_error", 32'(bus.order_error), 1);
        chk("t7_no_update", 32'(bus.update), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
